// File: rtl/speech_ram_writer_pkg.sv
// speech_ram_writer_pkg: FSM encoding and shared constants for the speech RAM writer.
package speech_ram_writer_pkg;

    localparam int DEFAULT_WADDR_W   = 20;
    localparam int DEFAULT_MAX_WORDS = 1048576;

    // Upper bits of speech_addr; the RAM port is two bits wider than the word address.
    localparam logic [1:0] SPEECH_ADDR_PAD = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // A capture owns the block from the accepted start until the done cycle.
    function automatic logic state_is_busy(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/speech_ram_writer_if.sv
// speech_ram_writer_if: byte stream in, speech RAM write port and status out.
// Optional build macro: SPEECH_RAM_WRITER_CHKSUM_EN adds the chksum signal.
//
// Handshake: a byte transfers on a rising clock edge where byte_valid and
// byte_ready are both high. byte_last is only meaningful on that edge. While
// byte_valid is high and byte_ready is low the source holds byte_in/byte_last
// stable. byte_ready never depends on byte_valid.
interface speech_ram_writer_if
    import speech_ram_writer_pkg::*;
#(
    parameter int WADDR_W = DEFAULT_WADDR_W
);
    logic               start;
    logic [7:0]         byte_in;
    logic               byte_valid;
    logic               byte_last;
    logic               byte_ready;
    logic [15:0]        speech_data;
    logic [WADDR_W+1:0] speech_addr;
    logic               speech_wren;
    logic [WADDR_W:0]   word_count;
    logic               busy;
    logic               done;
    logic               full;
`ifdef SPEECH_RAM_WRITER_CHKSUM_EN
    logic [15:0]        chksum;
`endif

    // Byte source / controller side.
    modport master (
        output start, byte_in, byte_valid, byte_last,
        input  byte_ready, speech_data, speech_addr, speech_wren,
        input  word_count, busy, done, full
`ifdef SPEECH_RAM_WRITER_CHKSUM_EN
        , input chksum
`endif
    );

    // Writer side.
    modport slave (
        input  start, byte_in, byte_valid, byte_last,
        output byte_ready, speech_data, speech_addr, speech_wren,
        output word_count, busy, done, full
`ifdef SPEECH_RAM_WRITER_CHKSUM_EN
        , output chksum
`endif
    );

endinterface

// File: rtl/speech_ram_writer_byte_packer.sv
// speech_ram_writer_byte_packer: holds the low byte of a word and joins it
// with the high byte. Loading a low byte clears the high half, so a word
// closed after a single byte comes out zero-padded.
module speech_ram_writer_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [7:0]  byte_in,
    output logic [15:0] word
);

    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;

    // Next holding-register contents: low byte opens a word, high byte completes it.
    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (load_lo) begin
            lo_d = byte_in;
            hi_d = 8'h00;
        end else if (load_hi) begin
            hi_d = byte_in;
        end
    end

    // Holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q <= 8'h00;
            hi_q <= 8'h00;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign word = {hi_q, lo_q};

endmodule

// File: rtl/speech_ram_writer.sv
// speech_ram_writer: packs a stream of speech bytes into 16-bit words (even
// byte low, odd byte high) and writes them sequentially into speech RAM.
// Optional build macro:
//   SPEECH_RAM_WRITER_CHKSUM_EN - adds bus.chksum, a mod-2^16 sum of written words.
module speech_ram_writer
    import speech_ram_writer_pkg::*;
#(
    parameter int WADDR_W   = DEFAULT_WADDR_W,
    parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic               clk,
    input  logic               reset,
    speech_ram_writer_if.slave bus,
    output state_t             state_dbg
);

    localparam logic [WADDR_W:0] MAX_CNT = (WADDR_W + 1)'(MAX_WORDS);

    state_t             state_q, state_d;
    logic [WADDR_W-1:0] waddr_q, waddr_d;
    logic [WADDR_W:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               end_q, end_d;

    logic               byte_ready;
    logic               wren;
    logic               done;
    logic               busy;
    logic               accept;
    logic               load_lo;
    logic               load_hi;
    logic               last_slot;
    logic [15:0]        word;

    assign accept    = bus.byte_valid & byte_ready;
    assign load_lo   = accept && (state_q == ST_LO);
    assign load_hi   = accept && (state_q == ST_HI);
    // The word in flight is the last one the RAM can take.
    assign last_slot = ((count_q + 1'b1) == MAX_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: two byte slots per word, one write cycle, then either the
    // next word or the closing done cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_LO;
            ST_LO:   if (accept)    state_d = bus.byte_last ? ST_WR : ST_HI;
            ST_HI:   if (accept)    state_d = ST_WR;
            ST_WR:   state_d = (end_q || last_slot) ? ST_FIN : ST_LO;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; strobes are held low during reset so a
    // write interrupted by reset never reaches the RAM.
    always_comb begin
        byte_ready = 1'b0;
        wren       = 1'b0;
        done       = 1'b0;
        busy       = state_is_busy(state_q);
        unique case (state_q)
            ST_LO, ST_HI: byte_ready = !reset;
            ST_WR:        wren       = !reset;
            ST_FIN:       done       = !reset;
            default:      ;
        endcase
    end

    // Address/count/flag updates. The address register may roll over after
    // the final word when MAX_WORDS fills the address space; no write follows
    // before the next start clears it.
    always_comb begin
        waddr_d = waddr_q;
        count_d = count_q;
        full_d  = full_q;
        end_d   = end_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    waddr_d = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                    end_d   = 1'b0;
                end
            end
            ST_LO, ST_HI: begin
                if (accept) end_d = bus.byte_last;
            end
            ST_WR: begin
                waddr_d = waddr_q + 1'b1;
                count_d = count_q + 1'b1;
                if (!end_q && last_slot) full_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            waddr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            waddr_q <= waddr_d;
            count_q <= count_d;
            full_q  <= full_d;
            end_q   <= end_d;
        end
    end

    speech_ram_writer_byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .load_lo (load_lo),
        .load_hi (load_hi),
        .byte_in (bus.byte_in),
        .word    (word)
    );

`ifdef SPEECH_RAM_WRITER_CHKSUM_EN
    logic [15:0] chksum_q, chksum_d;

    // Running sum: cleared by an accepted start, advanced on the edge ending each write.
    always_comb begin
        chksum_d = chksum_q;
        if ((state_q == ST_IDLE) && bus.start) begin
            chksum_d = 16'h0000;
        end else if (state_q == ST_WR) begin
            chksum_d = chksum_q + word;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            chksum_q <= 16'h0000;
        end else begin
            chksum_q <= chksum_d;
        end
    end

    assign bus.chksum = chksum_q;
`endif

    assign bus.byte_ready  = byte_ready;
    assign bus.speech_wren = wren;
    assign bus.speech_data = word;
    assign bus.speech_addr = {SPEECH_ADDR_PAD, waddr_q};
    assign bus.word_count  = count_q;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.full        = full_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_speech_ram_writer.sv
// tb_speech_ram_writer: directed and randomized captures against a
// transaction-level model of the speech RAM writer (small RAM: 4 words).
module tb_speech_ram_writer
    import speech_ram_writer_pkg::*;
;
    localparam int WADDR_W   = 2;
    localparam int MAX_WORDS = 4;
    localparam int AW        = WADDR_W + 2;
    localparam int EW        = AW + 16;

    logic   clk = 1'b0;
    logic   reset;
    state_t state_dbg;

    speech_ram_writer_if #(.WADDR_W(WADDR_W)) bus();

    speech_ram_writer #(
        .WADDR_W   (WADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected summary first");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int             n_cmp = 0;
    int             n_err = 0;
    logic [EW-1:0]  exp_q[$];     // expected {addr, data} per write, in order
    logic [EW-1:0]  wr_log[$];    // writes observed on the RAM port
    int             done_cnt = 0;
    logic [7:0]     cap_bytes[$]; // bytes of the utterance being sent

    // Behavioural model of the capture, one view per clock cycle.
    bit             m_active    = 0;  // capture open, bytes or a write pending
    bit             m_write_now = 0;  // this cycle is a RAM write
    bit             m_done_now  = 0;  // this cycle closes the capture
    bit             m_half      = 0;  // low byte of the current word held
    bit             m_end       = 0;  // word being written carries the last byte
    bit             m_full      = 0;
    int             m_words     = 0;
    logic [15:0]    m_chk       = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t state=%0d)",
                     name, act, exp, $time, state_dbg);
        end
    endtask

    function automatic logic [EW-1:0] log_at(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return '1;
    endfunction

    // ---------------- compare process ----------------
    initial begin : monitor
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("ready_in_reset", bus.byte_ready, 0);
                check("wren_in_reset", bus.speech_wren, 0);
                check("done_in_reset", bus.done, 0);
                m_active = 0; m_write_now = 0; m_done_now = 0; m_half = 0;
                m_end = 0; m_full = 0; m_words = 0; m_chk = 16'h0000;
                exp_q.delete();
            end else begin
                check("byte_ready", bus.byte_ready, m_active && !m_write_now);
                check("speech_wren", bus.speech_wren, m_write_now);
                check("done", bus.done, m_done_now);
                check("busy", bus.busy, m_active || m_done_now);
                check("word_count", bus.word_count, m_words);
                check("full", bus.full, m_full);
`ifdef SPEECH_RAM_WRITER_CHKSUM_EN
                check("chksum", bus.chksum, m_chk);
`endif
                if (bus.speech_wren) wr_log.push_back({bus.speech_addr, bus.speech_data});
                if (bus.done) done_cnt++;

                // advance the model to the next cycle
                if (m_done_now) begin
                    m_done_now = 0;
                end else if (!m_active) begin
                    if (bus.start) begin
                        m_active = 1; m_words = 0; m_full = 0; m_half = 0;
                        m_end = 0; m_chk = 16'h0000;
                    end
                end else if (m_write_now) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL write_expected: got a write slot, expected no queued word");
                    end else begin
                        e = exp_q.pop_front();
                        check("speech_addr", bus.speech_addr, e[EW-1:16]);
                        check("speech_data", bus.speech_data, e[15:0]);
                        m_chk = m_chk + e[15:0];
                    end
                    m_write_now = 0;
                    m_words++;
                    if (m_end || m_words == MAX_WORDS) begin
                        m_active   = 0;
                        m_done_now = 1;
                        m_full     = !m_end;
                    end
                end else if (bus.byte_valid) begin
                    if (m_half) begin
                        m_half = 0; m_write_now = 1; m_end = bus.byte_last;
                    end else if (bus.byte_last) begin
                        m_write_now = 1; m_end = 1;
                    end else begin
                        m_half = 1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input bit last, input int gap,
                             input bit rand_start, input int budget, output bit ok);
        bus.byte_valid = 1'b0;
        repeat (gap) begin
            bus.start     = rand_start && ($urandom_range(0, 5) == 0);
            bus.byte_last = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.byte_in    = b;
        bus.byte_last  = last;
        bus.byte_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            bus.start = rand_start && ($urandom_range(0, 5) == 0);
            @(negedge clk);
            ok = bus.byte_ready;
            @(posedge clk); #1;
        end
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        bus.byte_in    = 8'($urandom);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Queue the words the RAM must see for cap_bytes, then send the bytes the
    // capacity allows (the rest would never be accepted).
    task automatic run_capture(input bit do_start, input int min_gap, input int max_gap,
                               input bit rand_start);
        int n;
        int nw;
        int n_send;
        bit ok;
        logic [7:0] lo;
        logic [7:0] hi;
        n  = cap_bytes.size();
        nw = (n + 1) / 2;
        if (nw > MAX_WORDS) nw = MAX_WORDS;
        for (int k = 0; k < nw; k++) begin
            lo = cap_bytes[2*k];
            hi = (2*k + 1 < n) ? cap_bytes[2*k+1] : 8'h00;
            exp_q.push_back({AW'(k), hi, lo});
        end
        if (do_start) pulse_start();
        n_send = (n > 2 * MAX_WORDS) ? 2 * MAX_WORDS : n;
        for (int i = 0; i < n_send; i++) begin
            send_byte(cap_bytes[i], (i == n - 1), $urandom_range(min_gap, max_gap),
                      rand_start, 40, ok);
            check("byte_accepted", ok, 1);
        end
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while ((bus.busy || m_active || m_done_now) && i < 200) begin
            @(posedge clk); #1;
            i++;
        end
        check(name, bus.busy, 0);
    endtask

    task automatic begin_test();
        wr_log.delete();
        done_cnt = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        bit ok;
        int n;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.byte_ready, 0);
        check("rst_wren", bus.speech_wren, 0);
        check("rst_done", bus.done, 0);
        check("rst_full", bus.full, 0);
        check("rst_word_count", bus.word_count, 0);
        check("rst_addr", bus.speech_addr, 0);
        check("rst_data", bus.speech_data, 0);
        repeat (2) begin @(posedge clk); #1; end

        // even word count: 11,22,33,44
        begin_test();
        cap_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_capture(1, 0, 0, 0);
        wait_idle("a_idle");
        check("a_writes", wr_log.size(), 2);
        check("a_w0", log_at(0), 20'h0_2211);
        check("a_w1", log_at(1), 20'h1_4433);
        check("a_done_cnt", done_cnt, 1);
        check("a_word_count", bus.word_count, 2);
        check("a_full", bus.full, 0);
        check("a_model_words", m_words, 2);

        // odd byte count: last word zero-padded
        begin_test();
        cap_bytes = '{8'hAA, 8'hBB, 8'hCC};
        run_capture(1, 0, 0, 0);
        wait_idle("b_idle");
        check("b_writes", wr_log.size(), 2);
        check("b_w0", log_at(0), 20'h0_BBAA);
        check("b_w1", log_at(1), 20'h1_00CC);
        check("b_word_count", bus.word_count, 2);

        // capacity reached: 12 bytes into a 4-word RAM
        begin_test();
        cap_bytes.delete();
        for (int i = 1; i <= 12; i++) cap_bytes.push_back(8'(i));
        run_capture(1, 0, 0, 0);
        wait_idle("c_idle");
        send_byte(8'h09, 1'b0, 0, 1'b0, 10, ok);
        check("c_no_accept_after_full", ok, 0);
        check("c_writes", wr_log.size(), 4);
        check("c_w0", log_at(0), 20'h0_0201);
        check("c_w1", log_at(1), 20'h1_0403);
        check("c_w2", log_at(2), 20'h2_0605);
        check("c_w3", log_at(3), 20'h3_0807);
        check("c_full", bus.full, 1);
        check("c_done_cnt", done_cnt, 1);
        check("c_word_count", bus.word_count, 4);

        // start held from the write through done: only the idle-cycle start counts
        begin_test();
        cap_bytes = '{8'h5A, 8'hA5};
        run_capture(1, 0, 0, 0);
        bus.start = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.start = 1'b0;
        check("d_restarted_busy", bus.busy, 1);
        cap_bytes = '{8'h12, 8'h34};
        run_capture(0, 0, 0, 0);
        wait_idle("d_idle");
        check("d_writes", wr_log.size(), 2);
        check("d_w0", log_at(0), 20'h0_A55A);
        check("d_w1", log_at(1), 20'h0_3412);
        check("d_done_cnt", done_cnt, 2);
        check("d_full_cleared", bus.full, 0);

        // reset right after the first byte is accepted
        begin_test();
        pulse_start();
        send_byte(8'h77, 1'b0, 0, 1'b0, 40, ok);
        check("e_first_accept", ok, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("e_busy", bus.busy, 0);
        check("e_ready", bus.byte_ready, 0);
        check("e_wren", bus.speech_wren, 0);
        check("e_word_count", bus.word_count, 0);
        check("e_full", bus.full, 0);
        check("e_data", bus.speech_data, 0);
        check("e_no_write", wr_log.size(), 0);
        cap_bytes = '{8'h9C, 8'hC9};
        run_capture(1, 0, 0, 0);
        wait_idle("e_idle");
        check("e_writes", wr_log.size(), 1);
        check("e_w0", log_at(0), 20'h0_C99C);

        // same bytes back to back, then with one idle cycle per byte
        cap_bytes.delete();
        for (int i = 0; i < 6; i++) cap_bytes.push_back(8'($urandom));
        begin_test();
        run_capture(1, 0, 0, 0);
        wait_idle("f_cont_idle");
        check("f_cont_writes", wr_log.size(), 3);
        begin_test();
        run_capture(1, 1, 1, 0);
        wait_idle("f_gap_idle");
        check("f_gap_writes", wr_log.size(), 3);

`ifdef SPEECH_RAM_WRITER_CHKSUM_EN
        // checksum wraps: 0x0001 + 0xFFFF
        begin_test();
        cap_bytes = '{8'h01, 8'h00, 8'hFF, 8'hFF};
        run_capture(1, 0, 0, 0);
        wait_idle("h_idle");
        check("h_chksum", bus.chksum, 16'h0000);
        check("h_model_chk", m_chk, 16'h0000);
        check("h_done_cnt", done_cnt, 1);
`endif

        // randomized captures: lengths, gaps, stray starts and byte_last
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, 11);
            cap_bytes.delete();
            for (int i = 0; i < n; i++) cap_bytes.push_back(8'($urandom));
            repeat ($urandom_range(0, 3)) begin
                bus.byte_valid = 1'($urandom_range(0, 1));
                bus.byte_in    = 8'($urandom);
                @(posedge clk); #1;
            end
            bus.byte_valid = 1'b0;
            run_capture(1, 0, 2, 1);
            wait_idle("g_idle");
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/speech_ram_writer.md
Name: speech_ram_writer

Overview:
- Write side of the speech RAM path. The existing byte reader splits each 16-bit speech word into two bytes; this block does the reverse.
- Accepts a stream of 8-bit speech bytes over a valid/ready handshake and packs byte pairs into 16-bit words.
- Writes the words sequentially into speech RAM and reports word count, completion and overflow.
- Sits between the audio byte source and speech RAM; active only while the front-end is not reading.

Parameters:
- WADDR_W, 20, word-address width. Output speech_addr is {2'b0, word address}.
- MAX_WORDS, 1048576, RAM capacity in words. Must be ≤ 2^WADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new capture at word 0
- byte_in  in  8  speech byte
- byte_valid  in  1  byte_in is valid
- byte_last  in  1  qualifies the final byte of the utterance (sampled with byte_valid)
- byte_ready  out  1  block can accept a byte this cycle
- speech_data  out  16  word to write
- speech_addr  out  WADDR_W+2  {2'b0, word address}
- speech_wren  out  1  write strobe, one cycle per word
- word_count  out  WADDR_W+1  words written in the current capture
- busy  out  1  capture in progress
- done  out  1  one-cycle pulse when the capture ends
- full  out  1  sticky; capture stopped because RAM capacity was reached

Behaviour:
- Reset values: every output 0, FSM in IDLE, address counter 0, byte holding register 0.
- A byte is accepted when byte_valid & byte_ready in the same cycle.
- Byte order: the even byte (accepted first) goes to speech_data[7:0]; the odd byte goes to [15:8]. This matches the reader, which selects the low byte on byte address bit0 = 0.
- FSM states: IDLE, LO, HI, WR, FIN.
- IDLE: byte_ready=0, busy=0.
  - start → LO; clear word address, word_count and full.
- LO: byte_ready=1.
  - On accept, latch the low byte.
  - byte_last=0 → HI.
  - byte_last=1 → WR with the high byte zero-padded, and the end flag set.
- HI: byte_ready=1.
  - On accept, form the word.
  - Go to WR; set the end flag if byte_last=1.
- WR: byte_ready=0, speech_wren=1 for exactly one cycle.
  - speech_addr equals the current word address; speech_data is the packed word.
  - Next cycle: address and word_count each increment by 1.
  - Next state:
    - If the end flag is set → FIN.
    - Else if word_count+1 == MAX_WORDS → FIN with full=1.
    - Else → LO.
- FIN: done=1 for one cycle → IDLE.
  - full and word_count hold until the next start.
- Throughput: at most 2 bytes per 3 cycles. Latency from the high-byte accept to speech_wren is 1 cycle.
- busy = 1 in LO, HI, WR and FIN.
- start while busy is ignored.
- start in the same cycle as the FIN→IDLE transition is also ignored; it must be reasserted in IDLE.
- byte_valid while in IDLE or WR is not accepted; the source holds the byte.
- byte_last in HI with valid=0 has no effect; it is only sampled on accept.
- Address never wraps. full takes precedence over further bytes.
- reset asserted mid-capture:
  - Immediate return to IDLE with all outputs 0.
  - A partially packed byte is discarded.
  - Any speech_wren in that cycle is suppressed, because reset has priority in the same clock edge.

Optional Feature:
- Macro: SPEECH_RAM_WRITER_CHKSUM_EN.
- Defined:
  - Adds output chksum[15:0], a mod-2^16 sum of every word written.
  - Cleared on reset and on an accepted start.
  - Updated in the cycle after each speech_wren.
  - Stable when done pulses.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit: IDLE=0, LO=1, HI=2, WR=3, FIN=4);
  - SPEECH_ADDR_PAD = 2'b0;
  - default word-address width 20.
- Sub-module byte_packer (holding register plus zero-pad/concatenate logic) is natural and keeps the FSM focused on handshake and addressing.
- Address and count counters stay in the top module.

Test Plan:
- Four bytes 11,22,33,44 with byte_last on 44:
  - two writes: addr 0 data 16'h2211, then addr 1 data 16'h4433;
  - done pulses once; word_count=2; full=0.
- Three bytes AA,BB,CC with byte_last on CC:
  - writes 16'hBBAA at addr 0 and 16'h00CC at addr 1;
  - word_count=2.
- MAX_WORDS=4, 12 bytes streamed:
  - exactly 4 writes at addr 0..3, then full=1 and done;
  - byte_ready stays 0 afterwards; word_count=4.
- byte_valid toggled randomly with one idle cycle per byte: packed data and addresses are unchanged versus the continuous case; no byte is lost or duplicated.
- reset asserted in the cycle after the first byte is accepted:
  - no speech_wren; all outputs 0;
  - a following start plus 2 bytes writes addr 0.
- With SPEECH_RAM_WRITER_CHKSUM_EN defined, bytes 01,00,FF,FF: chksum=16'h0000 at done (16'h0001 + 16'hFFFF, wrapped).
